psum_accum: RTL and testbench
=============================

PSUM_ACCUM -- requirements
Module: psum_accum

Interface
REQ-001 SHALL have parameter NUM_PES, default 16, number of multiplier-switch lanes consumed.
REQ-002 SHALL have parameter IN_DATA_TYPE, default 24, signed product width per lane.
REQ-003 SHALL have parameter OUT_DATA_TYPE, default 32, signed accumulator and output width per lane; OUT_DATA_TYPE >= IN_DATA_TYPE.
REQ-004 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-005 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port i_start, input, 1, pulse; latches i_acc_len, clears partial sums, enters ACCUM.
REQ-007 SHALL have port i_acc_len, input, 8, products per result; 0 encodes 256.
REQ-008 SHALL have port i_valid, input, 1, product vector valid; driven by multiplier array o_valid, no backpressure.
REQ-009 SHALL have port i_data_bus, input, NUM_PES*IN_DATA_TYPE, lane i at bits [i*IN_DATA_TYPE +: IN_DATA_TYPE].
REQ-010 SHALL have port i_ready, input, 1, downstream accepts result when high with o_valid.
REQ-011 SHALL have port o_valid, output, 1, result vector available at queue head.
REQ-012 SHALL have port o_data_bus, output, NUM_PES*OUT_DATA_TYPE, head result, lane i at [i*OUT_DATA_TYPE +: OUT_DATA_TYPE].
REQ-013 SHALL have port o_busy, output, 1, high in ACCUM state.
REQ-014 SHALL have port o_drop, output, 1, sticky: a completed result was lost because the queue was full.

Function
REQ-015 SHALL implement FSM states IDLE and ACCUM; IDLE->ACCUM on i_start; ACCUM->ACCUM on i_start (restart, partial discarded); no other exit from ACCUM except reset.
REQ-016 SHALL ignore i_valid in IDLE, and on the i_start cycle itself.
REQ-017 SHALL keep a beat counter cnt (0..255); per accepted beat each lane: acc = (cnt==0 ? sext(data) : acc + sext(data)), sum modulo 2^OUT_DATA_TYPE (wrap, no saturation).
REQ-018 SHALL, on the beat where cnt == len-1, push the completed vector (including that beat) into the output queue and set cnt to 0; otherwise cnt increments.
REQ-019 SHALL present a pushed result on o_valid/o_data_bus the cycle after its final input beat (latency 1) when the queue was empty.
REQ-020 SHALL implement a 2-entry FIFO output queue; o_valid = not empty; pop when o_valid && i_ready.
REQ-021 SHALL hold o_data_bus stable while o_valid && !i_ready.
REQ-022 SHALL, on simultaneous push and pop, accept the push even when full (occupancy unchanged, order preserved).
REQ-023 SHALL, on push to a full queue without pop, discard the new result, keep queued entries, and set o_drop until reset.
REQ-024 SHALL, with len==1, push every beat directly (sext of input).
REQ-025 SHALL leave the queue and o_drop untouched by i_start.

Reset
REQ-026 SHALL on rst low immediately set: state IDLE, cnt 0, queue empty, o_valid 0, o_busy 0, o_drop 0, o_data_bus 0, accumulators 0.
REQ-027 SHALL, on reset mid-accumulation, discard partial sums and queued results; first i_start after release begins a fresh group.

Structure
REQ-028 SHALL place lane-width constants, the 2-state FSM enum and len-decode (0->256) function in a shared package.
REQ-029 SHALL use one sub-module, psum_lane, instantiated NUM_PES times via generate (one accumulator lane); FSM, counter and queue control in top level.

Verification
REQ-030 SHALL test: i_start len=4, 4 valid beats all lanes=+3 -> one o_valid cycle later, every lane 12; o_busy remains 1.
REQ-031 SHALL test: len=2, lane0 beats -5 then +2 (24-bit sign) -> lane0 output 0xFFFFFFFD.
REQ-032 SHALL test: len=1, i_ready=0, 3 beats values 1,2,3 -> queue holds 1,2; o_drop=1; after i_ready=1, outputs 1 then 2.
REQ-033 SHALL test: queue full, i_ready=1 same cycle as push -> no drop, outputs strictly in order.
REQ-034 SHALL test: len=0, 256 beats of 1 -> lanes output 256; len latched so changing i_acc_len mid-group has no effect.
REQ-035 SHALL test: rst asserted after 2 of 4 beats -> all outputs 0 immediately; new group after i_start yields correct sum without residue.

Source files
------------

// File: rtl/psum_accum_pkg.sv
// Shared lane-width defaults, accumulator FSM states and the group-length decode.
// A length code of 0 means a full 256-beat group.
package psum_accum_pkg;

   localparam int DEF_NUM_PES = 16;
   localparam int DEF_IN_W    = 24;
   localparam int DEF_OUT_W   = 32;
   localparam int LEN_W       = 8;
   localparam int QDEPTH      = 2;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_ACCUM = 1'b1
   } state_t;

   function automatic logic [LEN_W:0] decode_len(input logic [LEN_W-1:0] len);
      return (len == '0) ? 9'd256 : {1'b0, len};
   endfunction

endpackage

// File: rtl/psum_lane.sv
// One signed accumulator lane: sum_dat is the running sum including the current beat.
// Registered state updates one cycle after each accepted beat; no backpressure.
module psum_lane #(
   parameter int IN_W  = 24,
   parameter int OUT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             beat,
   input  logic             first,
   input  logic [IN_W-1:0]  in_dat,
   output logic [OUT_W-1:0] sum_dat
);

   logic [OUT_W-1:0] acc_q;
   logic [OUT_W-1:0] ext;

   assign ext     = OUT_W'($signed(in_dat));
   // The first beat of a group replaces whatever the register holds.
   assign sum_dat = first ? ext : (acc_q + ext);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         acc_q <= '0;
      end else if (clr) begin
         acc_q <= '0;
      end else if (beat) begin
         acc_q <= sum_dat;
      end
   end

endmodule

// File: rtl/psum_accum.sv
// Per-lane partial-sum accumulator over len beats; completed vectors enter a 2-deep queue (latency 1).
// No input backpressure: a result completing into a full queue with no pop is dropped and o_drop sticks.
module psum_accum
   import psum_accum_pkg::*;
#(
   parameter int NUM_PES       = DEF_NUM_PES,
   parameter int IN_DATA_TYPE  = DEF_IN_W,
   parameter int OUT_DATA_TYPE = DEF_OUT_W
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             i_start,
   input  logic [LEN_W-1:0]                 i_acc_len,
   input  logic                             i_valid,
   input  logic [NUM_PES*IN_DATA_TYPE-1:0]  i_data_bus,
   input  logic                             i_ready,
   output logic                             o_valid,
   output logic [NUM_PES*OUT_DATA_TYPE-1:0] o_data_bus,
   output logic                             o_busy,
   output logic                             o_drop
);

   localparam int OUT_BUS_W = NUM_PES * OUT_DATA_TYPE;

   state_t state_q, state_d;

   logic [LEN_W-1:0] cnt_q;
   logic [LEN_W:0]   len_q;
   logic             beat;
   logic             first_beat;
   logic             last_beat;

   logic [OUT_BUS_W-1:0] sum_bus;

   logic [OUT_BUS_W-1:0] q_dat [QDEPTH];
   logic                 rd_ptr_q;
   logic                 wr_ptr;
   logic [1:0]           q_cnt_q;
   logic [1:0]           q_cnt_d;
   logic                 q_full;
   logic                 pop;
   logic                 push_ok;
   logic                 drop;

   // ------------------------------------------------------------------
   // Control FSM
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (i_start) begin
         state_d = ST_ACCUM;
      end
   end

   assign o_busy = (state_q == ST_ACCUM);

   // Beats on the start cycle belong to no group and are discarded.
   assign beat       = (state_q == ST_ACCUM) && i_valid && !i_start;
   assign first_beat = (cnt_q == '0);
   assign last_beat  = beat && ({1'b0, cnt_q} == (len_q - 9'd1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= '0;
         len_q <= 9'd256;
      end else if (i_start) begin
         cnt_q <= '0;
         len_q <= decode_len(i_acc_len);
      end else if (beat) begin
         cnt_q <= last_beat ? '0 : (cnt_q + 8'd1);
      end
   end

   // ------------------------------------------------------------------
   // Accumulator lanes
   // ------------------------------------------------------------------
   for (genvar g = 0; g < NUM_PES; g++) begin : g_lane
      psum_lane #(
         .IN_W  (IN_DATA_TYPE),
         .OUT_W (OUT_DATA_TYPE)
      ) u_lane (
         .clk     (clk),
         .rst     (rst),
         .clr     (i_start),
         .beat    (beat),
         .first   (first_beat),
         .in_dat  (i_data_bus[g*IN_DATA_TYPE +: IN_DATA_TYPE]),
         .sum_dat (sum_bus[g*OUT_DATA_TYPE +: OUT_DATA_TYPE])
      );
   end

   // ------------------------------------------------------------------
   // Output queue
   // ------------------------------------------------------------------
   assign o_valid = (q_cnt_q != 2'd0);
   assign q_full  = (q_cnt_q == 2'd2);
   assign pop     = o_valid && i_ready;
   // A pop frees the head slot in the same cycle, so a full queue can still take a push.
   assign push_ok = last_beat && (!q_full || pop);
   assign drop    = last_beat && q_full && !pop;
   // Tail slot: head for an empty or full queue, the other slot when one entry is held.
   assign wr_ptr  = rd_ptr_q ^ q_cnt_q[0];
   assign q_cnt_d = q_cnt_q + {1'b0, push_ok} - {1'b0, pop};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < QDEPTH; i++) begin
            q_dat[i] <= '0;
         end
         rd_ptr_q <= 1'b0;
         q_cnt_q  <= 2'd0;
         o_drop   <= 1'b0;
      end else begin
         if (push_ok) begin
            q_dat[wr_ptr] <= sum_bus;
         end
         if (pop) begin
            rd_ptr_q <= ~rd_ptr_q;
         end
         q_cnt_q <= q_cnt_d;
         if (drop) begin
            o_drop <= 1'b1;
         end
      end
   end

   assign o_data_bus = o_valid ? q_dat[rd_ptr_q] : '0;

endmodule

// File: tb/tb_psum_accum.sv
// Directed bench for psum_accum with hand-computed expected sums.
module tb_psum_accum;

   localparam int NP = 16;
   localparam int IW = 24;
   localparam int OW = 32;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              i_start = 1'b0;
   logic [7:0]        i_acc_len = 8'd0;
   logic              i_valid = 1'b0;
   logic [NP*IW-1:0]  i_data_bus = '0;
   logic              i_ready = 1'b0;
   logic              o_valid;
   logic [NP*OW-1:0]  o_data_bus;
   logic              o_busy;
   logic              o_drop;

   int total = 0;
   int bad   = 0;

   psum_accum #(
      .NUM_PES       (NP),
      .IN_DATA_TYPE  (IW),
      .OUT_DATA_TYPE (OW)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .i_start    (i_start),
      .i_acc_len  (i_acc_len),
      .i_valid    (i_valid),
      .i_data_bus (i_data_bus),
      .i_ready    (i_ready),
      .o_valid    (o_valid),
      .o_data_bus (o_data_bus),
      .o_busy     (o_busy),
      .o_drop     (o_drop)
   );

   initial forever #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      total++;
      if (obs !== exp_v) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp_v);
      end
   endtask

   function automatic logic [OW-1:0] lane(input int i);
      return o_data_bus[i*OW +: OW];
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_all(input logic [IW-1:0] v);
      for (int i = 0; i < NP; i++) begin
         i_data_bus[i*IW +: IW] = v;
      end
   endtask

   task automatic start(input logic [7:0] len);
      i_start   = 1'b1;
      i_acc_len = len;
      tick();
      i_start = 1'b0;
   endtask

   task automatic beat_all(input logic [IW-1:0] v);
      i_valid = 1'b1;
      set_all(v);
      tick();
      i_valid = 1'b0;
   endtask

   initial begin
      logic early;

      // Reset state
      #12;
      check("rst_valid", 32'(o_valid), 32'd0);
      check("rst_busy",  32'(o_busy),  32'd0);
      check("rst_drop",  32'(o_drop),  32'd0);
      check("rst_data",  32'(o_data_bus == '0), 32'd1);
      tick();
      rst = 1'b1;
      tick();

      // Beats in IDLE are ignored
      beat_all(24'd9);
      beat_all(24'd9);
      check("idle_valid", 32'(o_valid), 32'd0);
      check("idle_busy",  32'(o_busy),  32'd0);

      // len=4, four beats of +3; a beat on the start cycle is ignored
      i_valid = 1'b1;
      set_all(24'd100);
      start(8'd4);
      i_valid = 1'b0;
      check("t1_busy", 32'(o_busy), 32'd1);
      beat_all(24'd3);
      beat_all(24'd3);
      beat_all(24'd3);
      check("t1_early", 32'(o_valid), 32'd0);
      beat_all(24'd3);
      check("t1_valid", 32'(o_valid), 32'd1);
      for (int i = 0; i < NP; i++) begin
         check("t1_lane", lane(i), 32'd12);
      end
      check("t1_busy2", 32'(o_busy), 32'd1);
      i_ready = 1'b1;
      tick();
      i_ready = 1'b0;
      check("t1_popped", 32'(o_valid), 32'd0);

      // len=2, lane0 -5 then +2
      start(8'd2);
      i_data_bus = '0;
      i_data_bus[0 +: IW] = 24'hFFFFFB;
      i_valid = 1'b1;
      tick();
      i_data_bus[0 +: IW] = 24'd2;
      tick();
      i_valid = 1'b0;
      check("t2_valid", 32'(o_valid), 32'd1);
      check("t2_lane0", lane(0), 32'hFFFFFFFD);
      check("t2_lane1", lane(1), 32'd0);
      i_ready = 1'b1;
      tick();
      i_ready = 1'b0;

      // len=1 with stalled sink: third result dropped
      start(8'd1);
      beat_all(24'd1);
      check("t3_valid", 32'(o_valid), 32'd1);
      check("t3_head1", lane(0), 32'd1);
      beat_all(24'd2);
      check("t3_nodrop", 32'(o_drop), 32'd0);
      beat_all(24'd3);
      check("t3_drop",   32'(o_drop), 32'd1);
      check("t3_hold",   lane(0),     32'd1);
      i_ready = 1'b1;
      tick();
      check("t3_head2",  lane(0),      32'd2);
      check("t3_valid2", 32'(o_valid), 32'd1);
      tick();
      check("t3_empty",  32'(o_valid), 32'd0);
      i_ready = 1'b0;
      check("t3_sticky", 32'(o_drop),  32'd1);

      // Async reset clears drop; then push and pop together on a full queue
      rst = 1'b0;
      #1;
      check("t4_rst_drop", 32'(o_drop), 32'd0);
      tick();
      rst = 1'b1;
      start(8'd1);
      beat_all(24'd10);
      beat_all(24'd11);
      check("t4_head10", lane(0), 32'd10);
      i_valid = 1'b1;
      set_all(24'd12);
      i_ready = 1'b1;
      tick();
      i_valid = 1'b0;
      check("t4_nodrop", 32'(o_drop),  32'd0);
      check("t4_head11", lane(0),      32'd11);
      check("t4_valid",  32'(o_valid), 32'd1);
      tick();
      check("t4_head12", lane(0),      32'd12);
      check("t4_valid2", 32'(o_valid), 32'd1);
      tick();
      check("t4_empty",  32'(o_valid), 32'd0);

      // len code 0 = 256 beats; length changes mid-group are not latched
      start(8'd0);
      early = 1'b0;
      for (int b = 1; b <= 256; b++) begin
         if (b == 100) i_acc_len = 8'd5;
         beat_all(24'd1);
         if (b < 256 && o_valid) early = 1'b1;
      end
      check("t5_early",  32'(early),   32'd0);
      check("t5_valid",  32'(o_valid), 32'd1);
      check("t5_lane0",  lane(0),      32'd256);
      check("t5_lane15", lane(15),     32'd256);
      tick();
      check("t5_popped", 32'(o_valid), 32'd0);
      i_ready = 1'b0;

      // Restart keeps the queue; reset mid-group clears everything
      start(8'd2);
      beat_all(24'd7);
      beat_all(24'd7);
      check("t6_q14", lane(0), 32'd14);
      start(8'd4);
      check("t6_keepq", 32'(o_valid), 32'd1);
      check("t6_keep14", lane(0), 32'd14);
      beat_all(24'd5);
      beat_all(24'd5);
      rst = 1'b0;
      #1;
      check("t6_rst_valid", 32'(o_valid), 32'd0);
      check("t6_rst_busy",  32'(o_busy),  32'd0);
      check("t6_rst_data",  32'(o_data_bus == '0), 32'd1);
      tick();
      rst = 1'b1;
      tick();
      start(8'd4);
      beat_all(24'd1);
      beat_all(24'd2);
      beat_all(24'd3);
      check("t6_partial", 32'(o_valid), 32'd0);
      beat_all(24'd4);
      check("t6_valid", 32'(o_valid), 32'd1);
      check("t6_lane0", lane(0), 32'd10);
      check("t6_lane7", lane(7), 32'd10);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
